// File: rtl/arb_pkg.sv
// Shared constants and grant-decoding helpers for the arbiter request queue.
package arb_pkg;
  localparam int NREQ  = 4;
  localparam int SRC_W = 2;

  function automatic logic is_onehot(input logic [NREQ-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NREQ; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  function automatic logic [SRC_W-1:0] oh2idx(input logic [NREQ-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) if (v[i]) idx |= SRC_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/arb_req_queue_if.sv
// Push/arbitration/issue bundle between the request queue and its neighbours.
interface arb_req_queue_if
  import arb_pkg::*;
#(parameter int DATA_W = 8);
  logic [NREQ-1:0]        push_valid;
  logic [NREQ*DATA_W-1:0] push_data;
  logic [NREQ-1:0]        push_ready;
  logic [NREQ-1:0]        req;
  logic                   enable;
  logic [NREQ-1:0]        grant;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   grant_err;
  logic [31:0]            grant_cnt;

  modport master (output push_valid, push_data, enable, grant,
                  input  push_ready, req, out_valid, out_data, out_src, grant_err, grant_cnt);
  modport slave  (input  push_valid, push_data, enable, grant,
                  output push_ready, req, out_valid, out_data, out_src, grant_err, grant_cnt);
endinterface

// File: rtl/arb_req_fifo.sv
// DEPTH x DATA_W synchronous FIFO for one requester; pointers wrap modulo DEPTH.
module arb_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o,
  output logic [DATA_W-1:0] head_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full/empty come from registered state only, so a pop never frees room for a same-edge push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/arb_req_queue.sv
// Per-source request queues feeding the 4-way arbiter; pops the granted queue one clk after enable_d.
// Optional per-source issue counters built only with `define ARB_Q_STATS_EN.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          reset,
  arb_req_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]             full, empty, pop_vec, push_vec;
  logic [NREQ-1:0][CW-1:0]     count;
  logic [NREQ-1:0][DATA_W-1:0] head;
  logic                        enable_d_q, out_valid_q, grant_err_q;
  logic [DATA_W-1:0]           out_data_q;
  logic [SRC_W-1:0]            out_src_q, gidx;
  logic                        g_onehot;

  for (genvar i = 0; i < NREQ; i++) begin : g_q
    assign push_vec[i] = bus.push_valid[i];
    arb_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (push_vec[i]),
      .pop_i  (pop_vec[i]),
      .data_i (bus.push_data[i*DATA_W +: DATA_W]),
      .full_o (full[i]),
      .empty_o(empty[i]),
      .count_o(count[i]),
      .head_o (head[i])
    );
    assign bus.req[i] = (count[i] != '0);
  end

  assign bus.push_ready = ~full;
  assign g_onehot = is_onehot(bus.grant);
  assign gidx     = oh2idx(bus.grant);
  // A grant to an empty queue is stale, not an error: it simply pops nothing.
  assign pop_vec  = (enable_d_q && g_onehot) ? (bus.grant & ~empty) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_d_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      enable_d_q  <= bus.enable;
      out_valid_q <= |pop_vec;
      if (|pop_vec) begin
        out_data_q <= head[gidx];
        out_src_q  <= gidx;
      end
      if (enable_d_q && (|bus.grant) && !g_onehot) grant_err_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.grant_err = grant_err_q;

`ifdef ARB_Q_STATS_EN
  logic [NREQ-1:0][7:0] cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        if (pop_vec[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
  end
  assign bus.grant_cnt = cnt_q;
`else
  assign bus.grant_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_arb_req_queue.sv
// Scoreboard bench for arb_req_queue: grant tasks queue expected issues, a negedge monitor checks them.
module tb_arb_req_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0, n_total = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  arb_req_queue_if #(.DATA_W(DATA_W)) bus ();
  arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef ARB_Q_STATS_EN
  localparam logic [7:0] STAT_EXP = 8'hFF;
`else
  localparam logic [7:0] STAT_EXP = 8'h00;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Issue monitor: every out_valid pulse must match the oldest expected issue.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL issue: unexpected src=%0d data=0x%0h expected none", bus.out_src, bus.out_data);
      end else begin
        check("issue", {22'h0, bus.out_src, bus.out_data}, {22'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int s, input logic [7:0] d);
    bus.push_valid[s] = 1'b1;
    bus.push_data[s*DATA_W +: DATA_W] = d;
    tick();
    bus.push_valid = '0;
  endtask

  // Strobe enable with grant g; the pop happens on the edge after enable_d, issue visible after it.
  task automatic grant_op(input logic [3:0] g, input bit issue, input logic [7:0] d,
                          input logic [1:0] s, input string nm);
    if (issue) exp_q.push_back({s, d});
    bus.grant = g; bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    tick();
    @(negedge clk);
    check(nm, {31'h0, bus.out_valid}, {31'h0, issue});
    bus.grant = '0;
  endtask

  initial begin
    bus.push_valid = '0; bus.push_data = '0; bus.enable = 1'b0; bus.grant = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_push_ready", {28'h0, bus.push_ready}, 32'hF);
    check("rst_req", {28'h0, bus.req}, 32'h0);
    check("rst_out", {21'h0, bus.out_valid, bus.out_src, bus.out_data}, 32'h0);
    check("rst_err", {31'h0, bus.grant_err}, 32'h0);
    check("rst_cnt", bus.grant_cnt, 32'h0);

    // Single push to source 2, req appears after the accepting edge.
    tick();
    bus.push_valid[2] = 1'b1; bus.push_data[2*DATA_W +: DATA_W] = 8'hA1;
    @(negedge clk);
    check("req_before_accept", {28'h0, bus.req}, 32'h0);
    tick();
    bus.push_valid = '0;
    @(negedge clk);
    check("req_after_push", {28'h0, bus.req}, 32'h4);
    grant_op(4'b0100, 1, 8'hA1, 2'd2, "pop_src2");
    check("req2_drained", {28'h0, bus.req}, 32'h0);

    // Stale grant to an empty queue.
    grant_op(4'b0100, 0, 8'h00, 2'd0, "stale_grant");
    check("stale_no_err", {31'h0, bus.grant_err}, 32'h0);

    // FIFO order on source 0.
    tick();
    push(0, 8'h11);
    push(0, 8'h22);
    grant_op(4'b0001, 1, 8'h11, 2'd0, "pop0_first");
    check("req0_still", {28'h0, bus.req}, 32'h1);
    grant_op(4'b0001, 1, 8'h22, 2'd0, "pop0_second");
    check("req0_drop", {28'h0, bus.req}, 32'h0);
    check("hold_data", {22'h0, bus.out_src, bus.out_data}, {22'h0, 2'd0, 8'h22});

    // Push and grant on the same edge into an empty queue: no issue yet.
    tick();
    bus.grant = 4'b0001; bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.push_valid[0] = 1'b1; bus.push_data[7:0] = 8'h77;
    tick();
    bus.push_valid = '0;
    @(negedge clk);
    check("empty_same_edge", {31'h0, bus.out_valid}, 32'h0);
    check("empty_same_req", {28'h0, bus.req}, 32'h1);
    bus.grant = '0;
    grant_op(4'b0001, 1, 8'h77, 2'd0, "late_issue");

    // Fill source 3, then a rejected push on the pop edge.
    tick();
    for (int i = 1; i <= DEPTH; i++) push(3, 8'h30 + 8'(i));
    @(negedge clk);
    check("full_ready", {28'h0, bus.push_ready}, 32'h7);
    tick();
    exp_q.push_back({2'd3, 8'h31});
    bus.grant = 4'b1000; bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.push_valid[3] = 1'b1; bus.push_data[3*DATA_W +: DATA_W] = 8'h35;
    tick();
    bus.push_valid = '0;
    @(negedge clk);
    check("full_pop_issue", {31'h0, bus.out_valid}, 32'h1);
    check("full_count", {29'h0, dut.count[3]}, 32'd3);
    check("ready_after_pop", {28'h0, bus.push_ready}, 32'hF);
    bus.grant = '0;
    for (int i = 2; i <= DEPTH; i++) grant_op(4'b1000, 1, 8'h30 + 8'(i), 2'd3, "drain3");
    check("req3_empty", {28'h0, bus.req}, 32'h0);

    // Long run on source 1 exercising counter saturation.
    for (int i = 0; i < 300; i++) begin
      tick();
      push(1, 8'(i));
      grant_op(4'b0010, 1, 8'(i), 2'd1, "stat_pop");
    end
    check("stat_cnt1", {24'h0, bus.grant_cnt[15:8]}, {24'h0, STAT_EXP});

    // Malformed grant with two queues non-empty.
    tick();
    bus.push_valid = 4'b0011; bus.push_data[7:0] = 8'h40; bus.push_data[15:8] = 8'h41;
    tick();
    bus.push_valid = '0;
    grant_op(4'b0011, 0, 8'h00, 2'd0, "multi_grant");
    check("err_set", {31'h0, bus.grant_err}, 32'h1);
    check("multi_req", {28'h0, bus.req}, 32'h3);
    grant_op(4'b0001, 1, 8'h40, 2'd0, "after_err0");
    grant_op(4'b0010, 1, 8'h41, 2'd1, "after_err1");
    check("err_sticky", {31'h0, bus.grant_err}, 32'h1);

    // Mid-operation reset discards queued entries.
    tick();
    push(2, 8'h55);
    #2 reset = 1'b1;
    #1;
    check("midrst_req", {28'h0, bus.req}, 32'h0);
    check("midrst_ready", {28'h0, bus.push_ready}, 32'hF);
    check("midrst_err", {31'h0, bus.grant_err}, 32'h0);
    check("midrst_cnt", bus.grant_cnt, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_no_issue", {31'h0, bus.out_valid}, 32'h0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Per-requester request buffering stage directly upstream of the 4-way mask arbiter.
- Holds up to DEPTH pending transactions per source and drives the arbiter's 4-bit req vector (bit i high while queue i is non-empty).
- Consumes the arbiter's one-hot grant on each enable strobe: pops the granted queue and presents that transaction downstream with its source index.

Parameters:
- DATA_W, 8, payload width per transaction.
- DEPTH, 4, entries per source queue; power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- push_valid  input  4  per-source push request.
- push_data  input  4*DATA_W  per-source payload; source i at bits [i*DATA_W +: DATA_W].
- push_ready  output  4  per-source "queue not full".
- req  output  4  request vector to the arbiter; bit i = queue i non-empty.
- enable  input  1  one-clk-wide arbitration strobe, the same strobe that clocks the arbiter's grant register.
- grant  input  4  one-hot grant from the arbiter.
- out_valid  output  1  one-cycle pulse: a transaction is issued.
- out_data  output  DATA_W  issued payload.
- out_src  output  2  issued source index.
- grant_err  output  1  sticky flag: malformed grant seen.
- grant_cnt  output  32  per-source issue counters, 8 bits each, source i at [i*8 +: 8]. Active only with the optional feature.

Behaviour:
- Reset (async, active-high) values:
  - All queues empty, so req=0 and push_ready=4'hF.
  - out_valid=0, out_data=0, out_src=0, grant_err=0, grant_cnt=0, enable_d=0.
- Push:
  - Queue i writes push_data slice on a rising clk where push_valid[i] & push_ready[i].
  - push_ready[i] = ~full[i], derived from registered count only. A full queue rejects the push even if a pop happens in the same cycle.
- req[i] = (count[i] != 0), combinational from registered count.
  - A push becomes visible on req the cycle after acceptance.
- Grant sampling:
  - The arbiter updates grant on the enable edge, so this block registers enable into enable_d.
  - grant is sampled on the clk edge where enable_d = 1.
- On a sample edge:
  - grant = 4'h0: no action.
  - grant one-hot, bit i, queue i non-empty: pop queue i. Next cycle out_valid=1, out_data=head[i], out_src=i. Latency is one clk from the sample edge.
  - grant one-hot, bit i, queue i empty (stale grant): no pop, out_valid stays 0, not an error.
  - grant has more than one bit set: no pop, grant_err set to 1 and held until reset.
- out_valid is 0 on every cycle that is not the cycle after a successful pop. out_data and out_src hold their last values when out_valid=0.
- Same queue, same edge, not full: push and pop both take effect; count unchanged; FIFO order preserved.
- Same queue, same edge, empty: a push and a grant both occur. The pop sees the registered empty state, so no issue; the entry is issued on a later grant.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits and ranges 0..DEPTH.
- Reset asserted mid-operation discards all queued entries and any in-flight issue immediately.

Optional Feature:
- Macro ARB_Q_STATS_EN.
- Defined: grant_cnt[i] increments by 1 on each successful pop of queue i and saturates at 8'hFF; cleared only by reset.
- Undefined: grant_cnt is tied to 32'h0 and no counter flops are built.

Decomposition:
- Package arb_pkg:
  - NREQ=4.
  - SRC_W=2.
  - One-hot check function, returns 1 iff exactly one bit is set.
  - One-hot-to-index encode function.
- Sub-module arb_req_fifo:
  - Single synchronous FIFO of DEPTH x DATA_W, with push, pop, full, empty, count and head outputs.
  - arb_req_queue instantiates it 4 times.

Test Plan:
- Reset, then push 0xA1 to source 2 -> push_ready=4'hF after reset; req=4'b0100 one cycle after the push.
- Push 0x11 then 0x22 to source 0; assert grant=4'b0001 on two enable strobes -> out_valid pulses with out_data 0x11 then 0x22, out_src=0, each one clk after enable_d; req[0] drops after the second pop.
- Push DEPTH=4 entries to source 3 -> push_ready[3]=0. Then a fifth push in the same cycle as a grant=4'b1000 pop -> push rejected, count 3, push_ready[3]=1 next cycle.
- grant=4'b0011 on an enable strobe with queues 0 and 1 non-empty -> no pop, out_valid=0, grant_err=1 and stays 1 until reset.
- grant=4'b0100 with queue 2 empty -> out_valid stays 0, grant_err stays 0.
- With ARB_Q_STATS_EN, 300 grants to source 1 with the queue kept non-empty -> grant_cnt[15:8]=8'hFF. Without the macro -> grant_cnt=0 throughout.
